// File: rtl/dsk_pkg.sv
// Shared types and constants for the floppy track streamer.
package dsk_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } dsk_state_e;

  // Word bases of the disk image regions; the address controller adds these.
  localparam logic [21:0] DSK_INT_BASE = 22'h100000;
  localparam logic [21:0] DSK_EXT_BASE = 22'h200000;

  // RAM words carry the even (earlier on the track) byte in the high half.
  localparam bit DSK_HIGH_BYTE_FIRST = 1'b1;

  function automatic logic [7:0] dsk_first_byte(input logic [15:0] word);
    return DSK_HIGH_BYTE_FIRST ? word[15:8] : word[7:0];
  endfunction

  function automatic logic [7:0] dsk_second_byte(input logic [15:0] word);
    return DSK_HIGH_BYTE_FIRST ? word[7:0] : word[15:8];
  endfunction

endpackage

// File: rtl/dsk_byte_fifo.sv
// Byte FIFO: writes two bytes per push, reads one byte per pop.
module dsk_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic [7:0]              push_first_i,
  input  logic [7:0]              push_second_i,
  input  logic                    pop_i,
  output logic [7:0]              head_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic [$clog2(DEPTH):0]  free_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  assign count_o = count_q;
  assign free_o  = CW'(DEPTH) - count_q;
  // Head is forced to zero while empty so stale storage never shows.
  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;

  // Pointer and occupancy next-state; flush discards everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(2);
      if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (push_i ? CW'(2) : CW'(0)) - (pop_ok ? CW'(1) : CW'(0));
    end
  end

  // Pointer/occupancy registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage writes both bytes of a word in the same clock.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q]          <= push_first_i;
      mem_q[wr_ptr_q + AW'(1)] <= push_second_i;
    end
  end

endmodule

// File: rtl/dsk_track_streamer.sv
// Streams a disk track from RAM through a byte FIFO, wrapping around the track.
module dsk_track_streamer
  import dsk_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 22
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memoryLatch,
  input  logic              dskReadAck,
  input  logic [15:0]       memDataIn,
  output logic [ADDR_W-1:0] dskReadAddr,
  input  logic [ADDR_W-1:0] trackBase,
  input  logic [ADDR_W-1:0] trackWords,
  input  logic              start,
  input  logic              stop,
  output logic [7:0]        byteOut,
  output logic              byteValid,
  input  logic              byteRd,
  output logic              busy,
  output logic              indexPulse,
  output logic              underrun,
  output logic              lenError
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  dsk_state_e        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              index_q, index_d;
  logic              underrun_q, underrun_d;
  logic              lenerr_q, lenerr_d;

  logic              flush;
  logic              capture;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     fifo_free;

  assign byteValid   = (fifo_count != '0);
  assign busy        = (state_q == STREAM);
  assign dskReadAddr = addr_q;
  assign indexPulse  = index_q;
  assign underrun    = underrun_q;
  assign lenError    = lenerr_q;

  // Control: stop beats start, start beats capture/pop; a slot is only
  // taken when a whole word fits, otherwise the address holds for a retry.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    offset_d   = offset_q;
    addr_d     = addr_q;
    index_d    = 1'b0;
    underrun_d = underrun_q;
    lenerr_d   = lenerr_q;
    flush      = 1'b0;
    capture    = 1'b0;
    if (stop) begin
      flush   = 1'b1;
      state_d = IDLE;
    end else if (start) begin
      flush = 1'b1;
      if (trackWords != '0) begin
        state_d    = STREAM;
        base_d     = trackBase;
        len_d      = trackWords;
        offset_d   = '0;
        addr_d     = trackBase;
        underrun_d = 1'b0;
        lenerr_d   = 1'b0;
      end else begin
        state_d  = IDLE;
        lenerr_d = 1'b1;
      end
    end else begin
      if (state_q == STREAM && dskReadAck && memoryLatch && fifo_free >= CW'(2)) begin
        capture = 1'b1;
        if (offset_q == len_q - ADDR_W'(1)) begin
          offset_d = '0;
          addr_d   = base_q;
          index_d  = 1'b1;
        end else begin
          offset_d = offset_q + ADDR_W'(1);
          addr_d   = base_q + offset_q + ADDR_W'(1);
        end
      end
      if (byteRd && !byteValid) underrun_d = 1'b1;
    end
  end

  // Control registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      offset_q   <= '0;
      addr_q     <= '0;
      index_q    <= 1'b0;
      underrun_q <= 1'b0;
      lenerr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      offset_q   <= offset_d;
      addr_q     <= addr_d;
      index_q    <= index_d;
      underrun_q <= underrun_d;
      lenerr_q   <= lenerr_d;
    end
  end

  dsk_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (flush),
    .push_i       (capture),
    .push_first_i (dsk_first_byte(memDataIn)),
    .push_second_i(dsk_second_byte(memDataIn)),
    .pop_i        (byteRd && !flush),
    .head_o       (byteOut),
    .count_o      (fifo_count),
    .free_o       (fifo_free)
  );

endmodule

// File: tb/tb_dsk_track_streamer.sv
// Directed bench for dsk_track_streamer with a small address-indexed RAM model.
module tb_dsk_track_streamer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memoryLatch = 1'b0;
  logic        dskReadAck = 1'b0;
  logic [15:0] memDataIn = 16'h0;
  logic [21:0] dskReadAddr;
  logic [21:0] trackBase = 22'h0;
  logic [21:0] trackWords = 22'h0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  byteOut;
  logic        byteValid;
  logic        byteRd = 1'b0;
  logic        busy;
  logic        indexPulse;
  logic        underrun;
  logic        lenError;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [21:0] addr;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic        idx;
  } row_t;

  row_t rows [4];

  dsk_track_streamer dut (
    .clk        (clk),
    .reset      (reset),
    .memoryLatch(memoryLatch),
    .dskReadAck (dskReadAck),
    .memDataIn  (memDataIn),
    .dskReadAddr(dskReadAddr),
    .trackBase  (trackBase),
    .trackWords (trackWords),
    .start      (start),
    .stop       (stop),
    .byteOut    (byteOut),
    .byteValid  (byteValid),
    .byteRd     (byteRd),
    .busy       (busy),
    .indexPulse (indexPulse),
    .underrun   (underrun),
    .lenError   (lenError)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_model(input logic [21:0] a);
    case (a)
      22'h000100: return 16'h1122;
      22'h000101: return 16'h3344;
      22'h000102: return 16'h5566;
      default:    return {a[7:0] ^ 8'h5A, a[7:0]};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic pulse_start(input logic [21:0] base, input logic [21:0] words);
    trackBase  = base;
    trackWords = words;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // One 4-clk granted bus cycle; RAM data valid on the last clk.
  task automatic slot(input bit pop_at_latch);
    dskReadAck = 1'b1;
    repeat (3) tick();
    memoryLatch = 1'b1;
    memDataIn   = mem_model(dskReadAddr);
    byteRd      = pop_at_latch;
    tick();
    memoryLatch = 1'b0;
    dskReadAck  = 1'b0;
    byteRd      = 1'b0;
    memDataIn   = 16'h0;
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check({name, "_valid"}, 32'(byteValid), 32'd1);
    check(name, 32'(byteOut), 32'(exp));
    byteRd = 1'b1;
    tick();
    byteRd = 1'b0;
  endtask

  task automatic pop_word(input string name, input logic [21:0] a);
    logic [15:0] w;
    w = mem_model(a);
    pop_check({name, "_hi"}, w[15:8]);
    pop_check({name, "_lo"}, w[7:0]);
  endtask

  initial begin
    rows[0] = '{addr: 22'h100, hi: 8'h11, lo: 8'h22, idx: 1'b0};
    rows[1] = '{addr: 22'h101, hi: 8'h33, lo: 8'h44, idx: 1'b0};
    rows[2] = '{addr: 22'h102, hi: 8'h55, lo: 8'h66, idx: 1'b1};
    rows[3] = '{addr: 22'h100, hi: 8'h11, lo: 8'h22, idx: 1'b0};

    // Reset state
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(byteValid), 32'd0);
    check("rst_byte", 32'(byteOut), 32'd0);
    check("rst_addr", 32'(dskReadAddr), 32'd0);
    check("rst_index", 32'(indexPulse), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_lenerr", 32'(lenError), 32'd0);

    // Basic stream with wrap
    pulse_start(22'h100, 22'd3);
    check("basic_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("basic_addr%0d", i), 32'(dskReadAddr), 32'(rows[i].addr));
      slot(1'b0);
      check($sformatf("basic_index%0d", i), 32'(indexPulse), 32'(rows[i].idx));
      pop_check($sformatf("basic_hi%0d", i), rows[i].hi);
      check($sformatf("basic_index_drop%0d", i), 32'(indexPulse), 32'd0);
      pop_check($sformatf("basic_lo%0d", i), rows[i].lo);
    end
    check("basic_empty", 32'(byteValid), 32'd0);

    // Backpressure: fill to 8 bytes, the 5th slot is skipped
    pulse_start(22'h200, 22'd16);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp_addr%0d", k), 32'(dskReadAddr), 32'h200 + 32'(k));
      slot(1'b0);
    end
    check("bp_addr_full", 32'(dskReadAddr), 32'h204);
    slot(1'b0);
    check("bp_addr_held", 32'(dskReadAddr), 32'h204);
    check("bp_underrun", 32'(underrun), 32'd0);
    pop_word("bp_w200", 22'h200);
    slot(1'b0);
    check("bp_addr_after", 32'(dskReadAddr), 32'h205);
    for (int k = 1; k <= 4; k++) pop_word($sformatf("bp_w%0d", k), 22'h200 + 22'(k));
    check("bp_empty", 32'(byteValid), 32'd0);

    // Simultaneous push and pop at occupancy 3
    pulse_start(22'h300, 22'd8);
    slot(1'b0);
    slot(1'b0);
    pop_check("sim_300hi", 8'h5A);
    check("sim_head", 32'(byteOut), 32'h00);
    slot(1'b1);
    pop_word("sim_w301", 22'h301);
    pop_word("sim_w302", 22'h302);
    check("sim_empty", 32'(byteValid), 32'd0);

    // Underrun and zero-length start
    byteRd = 1'b1;
    tick();
    byteRd = 1'b0;
    check("ur_set", 32'(underrun), 32'd1);
    repeat (3) tick();
    check("ur_sticky", 32'(underrun), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("ur_stop_busy", 32'(busy), 32'd0);
    check("ur_after_stop", 32'(underrun), 32'd1);
    pulse_start(22'h0, 22'd0);
    check("len_err", 32'(lenError), 32'd1);
    check("len_busy", 32'(busy), 32'd0);
    check("len_ur_kept", 32'(underrun), 32'd1);
    repeat (2) tick();
    check("len_busy_later", 32'(busy), 32'd0);

    // Restart mid-track, then stop+start together
    pulse_start(22'h400, 22'd4);
    check("rs_lenerr_clr", 32'(lenError), 32'd0);
    check("rs_ur_clr", 32'(underrun), 32'd0);
    slot(1'b0);
    slot(1'b0);
    check("rs_filled", 32'(byteValid), 32'd1);
    pulse_start(22'h2000, 22'd2);
    check("rs_flushed", 32'(byteValid), 32'd0);
    check("rs_addr", 32'(dskReadAddr), 32'h2000);
    check("rs_busy", 32'(busy), 32'd1);
    slot(1'b0);
    check("rs_addr_next", 32'(dskReadAddr), 32'h2001);
    check("rs_first_byte", 32'(byteOut), 32'h5A);
    stop  = 1'b1;
    start = 1'b1;
    tick();
    stop  = 1'b0;
    start = 1'b0;
    check("ss_busy", 32'(busy), 32'd0);
    check("ss_valid", 32'(byteValid), 32'd0);
    check("ss_addr_held", 32'(dskReadAddr), 32'h2001);

    // Asynchronous reset with 5 bytes buffered
    pulse_start(22'h500, 22'd8);
    slot(1'b0);
    slot(1'b0);
    slot(1'b0);
    pop_check("ar_pre", 8'h5A ^ 8'h00);
    dskReadAck = 1'b1;
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_valid", 32'(byteValid), 32'd0);
    check("ar_byte", 32'(byteOut), 32'd0);
    check("ar_addr", 32'(dskReadAddr), 32'd0);
    check("ar_index", 32'(indexPulse), 32'd0);
    check("ar_underrun", 32'(underrun), 32'd0);
    dskReadAck = 1'b0;
    #2;
    reset = 1'b0;
    tick();
    slot(1'b0);
    tick();
    check("ar_no_capture", 32'(byteValid), 32'd0);
    check("ar_idle", 32'(busy), 32'd0);
    check("ar_addr_idle", 32'(dskReadAddr), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
